eq_string_writer: RTL and testbench

Producer side of the 48-character on-screen text line: formats a signed 16-bit parameter into right-justified decimal ASCII and writes it into a 384-bit line buffer. The 12-block string renderer consumes that buffer. Used by the equalizer UI controller to refresh band frequency and gain labels. The visible string changes in a single cycle per request, so the renderer never displays a half-written field.

---
 rtl/eq_text_pkg.sv | 28 ++
 rtl/bin_to_bcd16.sv | 61 ++++++
 rtl/eq_string_writer.sv | 148 ++++++++++++++
 tb/tb_eq_string_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_text_pkg.sv
// rtl/eq_text_pkg.sv - shared types and constants for the text line writer
// Holds the writer FSM states, ASCII codes and the BCD significant-digit helper.
package eq_text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_FORMAT,
    ST_COMMIT
  } writer_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int MAX_FIELD = 8;

  // Zero still prints one digit, so the count never drops below 1.
  function automatic logic [2:0] bcd_digits(input logic [19:0] bcd);
    if (|bcd[19:16]) return 3'd5;
    if (|bcd[15:12]) return 3'd4;
    if (|bcd[11:8])  return 3'd3;
    if (|bcd[7:4])   return 3'd2;
    return 3'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd16.sv
// rtl/bin_to_bcd16.sv - sequential 16-bit binary to 5-digit BCD converter
// One shift-add-3 iteration per cycle; done_o is high during the final iteration.
module bin_to_bcd16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        done_o
);

  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [19:0] adj;
  logic        unused_adj_msb;

  // The top digit never reaches 5 for a 16-bit input, so its carry-out is dropped.
  assign unused_adj_msb = adj[19];

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[18:0], bin_q[15]};
      bin_d = {bin_q[14:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = run_q && (cnt_q == 4'd15);

endmodule

// File: rtl/eq_string_writer.sv
// rtl/eq_string_writer.sv - formats a signed value into a right-justified field of the text line
// Fields are built in a shadow buffer and published to string_out in one cycle.
module eq_string_writer
  import eq_text_pkg::*;
#(
  parameter int NUM_CHARS = 48
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [15:0]            value,
  input  logic [5:0]             char_pos,
  input  logic [3:0]             field_width,
  output logic [8*NUM_CHARS-1:0] string_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [8*NUM_CHARS-1:0] BLANK_LINE = {NUM_CHARS{ASCII_SPACE}};

  writer_state_t          state_q, state_d;
  logic [8*NUM_CHARS-1:0] shadow_q, shadow_d;
  logic [8*NUM_CHARS-1:0] string_q, string_d;
  logic                   done_q, done_d;
  logic                   neg_q, neg_d;
  logic [5:0]             pos_q, pos_d;
  logic [3:0]             width_q, width_d;
  logic [3:0]             k_q, k_d;

  logic        bcd_start, bcd_done;
  logic [19:0] bcd;
  logic [15:0] mag;
  logic [3:0]  w_clamped;
  logic [2:0]  ndig;
  logic [3:0]  need;
  logic [3:0]  digit;
  logic [6:0]  wr_pos;
  logic [7:0]  wr_char;
  logic        wr_en;

  bin_to_bcd16 u_bcd (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .start_i(bcd_start),
    .bin_i  (mag),
    .bcd_o  (bcd),
    .done_o (bcd_done)
  );

  // Two's-complement negate wraps -32768 onto 0x8000, which is the correct magnitude.
  assign mag       = value[15] ? (~value + 16'd1) : value;
  assign w_clamped = (field_width > 4'(MAX_FIELD)) ? 4'(MAX_FIELD) : field_width;
  assign ndig      = bcd_digits(bcd);
  assign need      = {1'b0, ndig} + {3'b0, neg_q};
  assign wr_pos    = {1'b0, pos_q} + {3'b0, width_q} - 7'd1 - {3'b0, k_q};

  always_comb begin
    case (k_q)
      4'd0:    digit = bcd[3:0];
      4'd1:    digit = bcd[7:4];
      4'd2:    digit = bcd[11:8];
      4'd3:    digit = bcd[15:12];
      4'd4:    digit = bcd[19:16];
      default: digit = 4'd0;
    endcase
  end

  // k_q counts characters from the right edge of the field.
  always_comb begin
    if (need > width_q)                          wr_char = ASCII_HASH;
    else if (k_q < {1'b0, ndig})                 wr_char = ASCII_ZERO + {4'b0, digit};
    else if (neg_q && (k_q == {1'b0, ndig}))     wr_char = ASCII_MINUS;
    else                                         wr_char = ASCII_SPACE;
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    string_d  = string_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    pos_d     = pos_q;
    width_d   = width_q;
    k_d       = k_q;
    bcd_start = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          shadow_d = BLANK_LINE;
          string_d = BLANK_LINE;
        end else if (start) begin
          neg_d     = value[15];
          pos_d     = char_pos;
          width_d   = w_clamped;
          bcd_start = 1'b1;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        k_d = '0;
        if (bcd_done) state_d = (width_q == 4'd0) ? ST_COMMIT : ST_FORMAT;
      end
      ST_FORMAT: begin
        wr_en = (wr_pos < 7'(NUM_CHARS));
        if (k_q == width_q - 4'd1) state_d = ST_COMMIT;
        else                       k_d = k_q + 4'd1;
      end
      ST_COMMIT: begin
        string_d = shadow_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (wr_en && (wr_pos == 7'(i))) shadow_d[8*(NUM_CHARS-i)-1 -: 8] = wr_char;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= BLANK_LINE;
      string_q <= BLANK_LINE;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      pos_q    <= '0;
      width_q  <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      string_q <= string_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      pos_q    <= pos_d;
      width_q  <= width_d;
      k_q      <= k_d;
    end
  end

  assign string_out = string_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eq_string_writer.sv
// tb/tb_eq_string_writer.sv - scoreboard bench for eq_string_writer
// Expected lines come from a decimal-text model of the on-screen line.
module tb_eq_string_writer;

  localparam int NC = 48;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [15:0]   value = '0;
  logic [5:0]    char_pos = '0;
  logic [3:0]    field_width = '0;
  logic [8*NC-1:0] string_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  byte             ref_bytes[NC];
  logic [8*NC-1:0] committed;
  logic [8*NC-1:0] exp_line[$];
  int              exp_cyc[$];

  eq_string_writer #(.NUM_CHARS(NC)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .clear      (clear),
    .value      (value),
    .char_pos   (char_pos),
    .field_width(field_width),
    .string_out (string_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  function automatic logic [8*NC-1:0] pack_line();
    logic [8*NC-1:0] r;
    for (int i = 0; i < NC; i++) r[8*(NC-i)-1 -: 8] = ref_bytes[i];
    return r;
  endfunction

  function automatic void blank_model();
    for (int i = 0; i < NC; i++) ref_bytes[i] = 8'h20;
  endfunction

  // Print the number as text, right-justify it, then drop characters beyond the line end.
  function automatic void apply_field(input logic signed [15:0] v, input int pos, input int fw);
    int  w;
    int  mag;
    byte txt[$];
    byte fld[$];
    w   = (fw > 8) ? 8 : fw;
    mag = (v < 0) ? -int'(v) : int'(v);
    do begin
      txt.push_front(byte'(8'h30 + mag % 10));
      mag = mag / 10;
    end while (mag > 0);
    if (v < 0) txt.push_front(8'h2D);
    for (int j = 0; j < w; j++) begin
      if (txt.size() > w)            fld.push_back(8'h23);
      else if (j < w - txt.size())   fld.push_back(8'h20);
      else                           fld.push_back(txt[j - (w - txt.size())]);
    end
    for (int j = 0; j < w; j++) if (pos + j < NC) ref_bytes[pos + j] = fld[j];
  endfunction

  always @(negedge Clk) begin
    if (!Reset) begin
      if (done) begin
        tests++;
        if (exp_line.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done got done=1 want done=0 at cycle %0d", cyc);
        end else begin
          logic [8*NC-1:0] l;
          int              c;
          l = exp_line.pop_front();
          c = exp_cyc.pop_front();
          if (string_out !== l) begin
            fails++;
            $display("FAIL string_out got %h want %h", string_out, l);
          end
          tests++;
          if (cyc != c) begin
            fails++;
            $display("FAIL done_latency got cycle %0d want cycle %0d", cyc, c);
          end
          tests++;
          if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_in_done got %b want 0", busy);
          end
          committed = l;
        end
      end else begin
        tests++;
        if (string_out !== committed) begin
          fails++;
          $display("FAIL string_stable got %h want %h", string_out, committed);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] v, input int pos, input int fw);
    int wc;
    @(negedge Clk);
    value       = v;
    char_pos    = 6'(pos);
    field_width = 4'(fw);
    start       = 1'b1;
    wc = (fw > 8) ? 8 : fw;
    apply_field(v, pos, fw);
    exp_line.push_back(pack_line());
    exp_cyc.push_back(cyc + 18 + wc);
    @(negedge Clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start got %b want 1", busy);
    end
  endtask

  task automatic wait_done();
    for (int n = 0; n < 80 && exp_line.size() != 0; n++) @(negedge Clk);
    tests++;
    if (exp_line.size() != 0) begin
      fails++;
      $display("FAIL done_timeout got pending=%0d want 0", exp_line.size());
      exp_line.delete();
      exp_cyc.delete();
    end
  endtask

  task automatic do_clear();
    @(negedge Clk);
    clear = 1'b1;
    @(posedge Clk);
    blank_model();
    committed = pack_line();
    @(negedge Clk);
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] rv;
    blank_model();
    committed = pack_line();
    repeat (3) @(negedge Clk);
    tests++;
    if (string_out !== committed) begin
      fails++;
      $display("FAIL reset_string got %h want %h", string_out, committed);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk);

    issue(16'd1234, 0, 6);           wait_done();
    issue(-16'sd5, 10, 3);           wait_done();
    issue(16'h8000, 20, 6);          wait_done();
    issue(16'h8000, 20, 5);          wait_done();
    issue(16'd7, 46, 4);             wait_done();
    issue(16'd0, 30, 1);             wait_done();
    issue(16'd32767, 35, 12);        wait_done();
    issue(16'd99, 2, 0);             wait_done();

    // A second start while busy must be ignored.
    issue(16'd4242, 40, 4);
    repeat (5) @(negedge Clk);
    value = 16'd999; char_pos = 6'd0; field_width = 4'd8; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_done();
    repeat (30) @(negedge Clk);

    // clear beats a simultaneous start.
    @(negedge Clk);
    value = 16'd55; char_pos = 6'd5; field_width = 4'd4; start = 1'b1; clear = 1'b1;
    @(posedge Clk);
    blank_model();
    committed = pack_line();
    @(negedge Clk);
    start = 1'b0; clear = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL clear_start_busy got %b want 0", busy); end
    repeat (30) @(negedge Clk);

    issue(-16'sd321, 12, 5);         wait_done();

    // Reset landing in the middle of FORMAT.
    issue(16'd4321, 30, 8);
    repeat (20) @(negedge Clk);
    #2 Reset = 1'b1;
    blank_model();
    committed = pack_line();
    exp_line.delete();
    exp_cyc.delete();
    #1;
    tests++;
    if (string_out !== committed) begin
      fails++;
      $display("FAIL reset_mid_string got %h want %h", string_out, committed);
    end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_mid_done got %b want 0", done); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid_busy got %b want 0", busy); end
    @(negedge Clk);
    #2 Reset = 1'b0;
    issue(-16'sd87, 0, 4);           wait_done();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
      end else begin
        case ($urandom_range(0, 3))
          0:       rv = 16'($urandom_range(0, 30)) - 16'd15;
          1:       rv = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
          default: rv = 16'($urandom);
        endcase
        issue(rv, $urandom_range(0, 63), $urandom_range(0, 15));
        wait_done();
      end
    end
    repeat (5) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
